// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Sequences fetch / decode / execute / writeback and drives every datapath
// strobe and mux select. Memory states stall on mem_ready, bounded by a
// watchdog that raises a sticky bus_err and forces the FSM back to FETCH.
// Optional feature: define ZICSR_TRAP_EN to add a TRAP state for illegal
// and SYSTEM (1110011) opcodes; without it those opcodes behave as NOPs.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, PC <- PC + 4 when mem_ready
// DECODE   | register read, branch target = OldPC + ImmB
// MEMADR   | load/store address = RD1 + imm
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access, write strobe on mem_ready
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, load PC with target when taken
// JAL      | PC <- target, ALUOut <- OldPC + 4
// JALR     | target = RD1 + ImmI, then JAL
// UPPER    | LUI (0 + ImmU) / AUIPC (OldPC + ImmU)
// TRAP     | PC <- sign-extended imm (ZICSR_TRAP_EN only)

module multicycle_control_fsm #(
   parameter int MEM_WAIT_MAX = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] imm_src,
   output logic       bus_err,
   output logic       illegal
);

   localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_UPPER    = 4'd12;
`ifdef ZICSR_TRAP_EN
   localparam logic [3:0] S_TRAP     = 4'd13;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
`endif

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic [3:0]    state, state_next;
   logic [CW-1:0] wait_cnt, wait_next;
   logic          stall_state, expire, taken;
   logic          pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

   // ALU funct decode lives in the ALU decoder, not here
   logic unused_funct7b5;
   assign unused_funct7b5 = funct7b5;

   // Branch condition from the comparator flags
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = lt;
         3'b101:  taken = !lt;
         3'b110:  taken = ltu;
         3'b111:  taken = !ltu;
         default: taken = 1'b0;
      endcase
   end

   // Watchdog: counts stalled cycles in memory states; ready beats expiry
   always_comb begin
      stall_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
      expire      = (MEM_WAIT_MAX != 0) && stall_state && !mem_ready && (wait_cnt == WAIT_MAX);
      wait_next   = '0;
      if (stall_state && !mem_ready && !expire) begin
         wait_next = (wait_cnt != '1) ? wait_cnt + CW'(1) : wait_cnt;
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      state_next    = state;
      pc_write_raw  = 1'b0;
      adr_src       = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      imm_src       = 3'b000;
      illegal_raw   = 1'b0;
      case (state)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_next   = S_DECODE;
            end else if (expire) begin
               state_next = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 3'b010;
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_LUI, OP_AUIPC:  state_next = S_UPPER;
`ifdef ZICSR_TRAP_EN
               OP_SYSTEM:         state_next = S_TRAP;
               default: begin
                  illegal_raw = 1'b1;
                  state_next  = S_TRAP;
               end
`else
               default: begin
                  illegal_raw = 1'b1;
                  state_next  = S_FETCH;
               end
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            imm_src    = op[5] ? 3'b001 : 3'b000;
            state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready)   state_next = S_MEMWB;
            else if (expire) state_next = S_FETCH;
         end
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            if (mem_ready) begin
               mem_write_raw = 1'b1;
               state_next    = S_FETCH;
            end else if (expire) begin
               state_next = S_FETCH;
            end
         end
         S_EXECR: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b10;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_op     = 2'b10;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a    = 2'b10;
            alu_op       = 2'b01;
            pc_write_raw = taken;
            state_next   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a    = 2'b01;
            alu_src_b    = 2'b10;
            pc_write_raw = 1'b1;
            state_next   = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = S_JAL;
         end
         S_UPPER: begin
            alu_src_a  = op[5] ? 2'b11 : 2'b01;
            alu_src_b  = 2'b01;
            imm_src    = 3'b011;
            state_next = S_ALUWB;
         end
`ifdef ZICSR_TRAP_EN
         S_TRAP: begin
            alu_src_a    = 2'b11;
            alu_src_b    = 2'b01;
            result_src   = 2'b10;
            pc_write_raw = 1'b1;
            state_next   = S_FETCH;
         end
`endif
         default: state_next = S_FETCH;
      endcase
   end

   // Strobes are held low while reset is asserted
   assign pc_write  = rst_n & pc_write_raw;
   assign mem_write = rst_n & mem_write_raw;
   assign ir_write  = rst_n & ir_write_raw;
   assign reg_write = rst_n & reg_write_raw;
   assign illegal   = rst_n & illegal_raw;

   // State, watchdog counter and sticky bus error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         if (expire) bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (watchdog limit set to 4).
// Outputs are packed into one signature:
// {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
//  alu_src_a, alu_src_b, alu_op, imm_src, illegal}

module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'b0010011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       lt = 1'b0;
   logic       ltu = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, bus_err, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [2:0] imm_src;
   logic [16:0] sig;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.MEM_WAIT_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .imm_src(imm_src), .bus_err(bus_err), .illegal(illegal)
   );

   assign sig = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                 alu_src_a, alu_src_b, alu_op, imm_src, illegal};

   localparam logic [16:0] FETCH_RDY = 17'b1_0_0_1_0_10_00_10_00_000_0;
   localparam logic [16:0] FETCH_STL = 17'b0_0_0_0_0_10_00_10_00_000_0;
   localparam logic [16:0] DEC       = 17'b0_0_0_0_0_00_01_01_00_010_0;
   localparam logic [16:0] DEC_ILL   = 17'b0_0_0_0_0_00_01_01_00_010_1;
   localparam logic [16:0] EXECI     = 17'b0_0_0_0_0_00_10_01_10_000_0;
   localparam logic [16:0] EXECR     = 17'b0_0_0_0_0_00_10_00_10_000_0;
   localparam logic [16:0] ALUWB     = 17'b0_0_0_0_1_00_00_00_00_000_0;
   localparam logic [16:0] MEMADR_LD = 17'b0_0_0_0_0_00_10_01_00_000_0;
   localparam logic [16:0] MEMADR_ST = 17'b0_0_0_0_0_00_10_01_00_001_0;
   localparam logic [16:0] MEMACC    = 17'b0_1_0_0_0_00_00_00_00_000_0;
   localparam logic [16:0] MEMWB     = 17'b0_0_0_0_1_01_00_00_00_000_0;
   localparam logic [16:0] MEMWR_RDY = 17'b0_1_1_0_0_00_00_00_00_000_0;
   localparam logic [16:0] BR_T      = 17'b1_0_0_0_0_00_10_00_01_000_0;
   localparam logic [16:0] BR_NT     = 17'b0_0_0_0_0_00_10_00_01_000_0;
   localparam logic [16:0] JAL       = 17'b1_0_0_0_0_00_01_10_00_000_0;
   localparam logic [16:0] LUI       = 17'b0_0_0_0_0_00_11_01_00_011_0;
   localparam logic [16:0] AUIPC     = 17'b0_0_0_0_0_00_01_01_00_011_0;
   localparam logic [16:0] TRAP      = 17'b1_0_0_0_0_10_11_01_00_000_0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      tick();
      n_cmp++;
      if ({pc_write, ir_write, mem_write, reg_write, illegal} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_strobes_1: got %b want 00000", {pc_write, ir_write, mem_write, reg_write, illegal});
      end
      tick();
      #1;
      n_cmp++;
      if (sig !== FETCH_STL) begin
         n_fail++;
         $display("FAIL reset_fetch_gated: sig %05h want %05h", sig, FETCH_STL);
      end
      n_cmp++;
      if (bus_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_bus_err: got %b want 0", bus_err);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (sig !== FETCH_RDY) begin
         n_fail++;
         $display("FAIL reset_release: sig %05h want %05h", sig, FETCH_RDY);
      end
   endtask

   task automatic test_addi();
      logic [16:0] exp [5];
      exp = '{FETCH_RDY, DEC, EXECI, ALUWB, FETCH_RDY};
      op = 7'b0010011;
      mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (sig !== exp[i]) begin
            n_fail++;
            $display("FAIL addi step %0d: sig %05h want %05h", i, sig, exp[i]);
         end
         if (i != 4) tick();
      end
   endtask

   task automatic test_rtype();
      logic [16:0] exp [5];
      exp = '{FETCH_RDY, DEC, EXECR, ALUWB, FETCH_RDY};
      op = 7'b0110011;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (sig !== exp[i]) begin
            n_fail++;
            $display("FAIL rtype step %0d: sig %05h want %05h", i, sig, exp[i]);
         end
         if (i != 4) tick();
      end
   endtask

   task automatic test_load_stall();
      logic [16:0] exp [9];
      logic        rdy [9];
      exp = '{FETCH_RDY, DEC, MEMADR_LD, MEMACC, MEMACC, MEMACC, MEMACC, MEMWB, FETCH_RDY};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      op = 7'b0000011;
      for (int i = 0; i < 9; i++) begin
         mem_ready = rdy[i];
         #1;
         n_cmp++;
         if (sig !== exp[i]) begin
            n_fail++;
            $display("FAIL lw_stall step %0d: sig %05h want %05h", i, sig, exp[i]);
         end
         if (i != 8) tick();
      end
      n_cmp++;
      if (bus_err !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_no_bus_err: got %b want 0", bus_err);
      end
   endtask

   // fetch stalls 2, then store stalls up to the limit before ready arrives
   task automatic test_store_ready_wins();
      logic [16:0] exp [11];
      logic        rdy [11];
      exp = '{FETCH_STL, FETCH_STL, FETCH_RDY, DEC, MEMADR_ST,
              MEMACC, MEMACC, MEMACC, MEMACC, MEMWR_RDY, FETCH_RDY};
      rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      op = 7'b0100011;
      for (int i = 0; i < 11; i++) begin
         mem_ready = rdy[i];
         #1;
         n_cmp++;
         if (sig !== exp[i]) begin
            n_fail++;
            $display("FAIL sw_ready_wins step %0d: sig %05h want %05h", i, sig, exp[i]);
         end
         if (i != 10) tick();
      end
      n_cmp++;
      if (bus_err !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_no_bus_err: got %b want 0", bus_err);
      end
   endtask

   task automatic test_branch();
      // {funct3, zero, lt, ltu, taken}
      logic [6:0] cases [6];
      logic [16:0] exp [4];
      cases = '{{3'b001, 1'b0, 1'b0, 1'b0, 1'b1},
                {3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
                {3'b000, 1'b1, 1'b0, 1'b0, 1'b1},
                {3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
                {3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
                {3'b010, 1'b1, 1'b1, 1'b1, 1'b0}};
      op = 7'b1100011;
      mem_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         funct3 = cases[c][6:4];
         zero   = cases[c][3];
         lt     = cases[c][2];
         ltu    = cases[c][1];
         exp = '{FETCH_RDY, DEC, (cases[c][0] ? BR_T : BR_NT), FETCH_RDY};
         for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (sig !== exp[i]) begin
               n_fail++;
               $display("FAIL branch case %0d step %0d: sig %05h want %05h", c, i, sig, exp[i]);
            end
            if (i != 3) tick();
         end
      end
      zero = 1'b0;
      lt   = 1'b0;
      ltu  = 1'b0;
   endtask

   task automatic test_jumps();
      logic [16:0] exp_jal [5];
      logic [16:0] exp_jalr [6];
      exp_jal  = '{FETCH_RDY, DEC, JAL, ALUWB, FETCH_RDY};
      exp_jalr = '{FETCH_RDY, DEC, MEMADR_LD, JAL, ALUWB, FETCH_RDY};
      op = 7'b1101111;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (sig !== exp_jal[i]) begin
            n_fail++;
            $display("FAIL jal step %0d: sig %05h want %05h", i, sig, exp_jal[i]);
         end
         if (i != 4) tick();
      end
      op = 7'b1100111;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++;
         if (sig !== exp_jalr[i]) begin
            n_fail++;
            $display("FAIL jalr step %0d: sig %05h want %05h", i, sig, exp_jalr[i]);
         end
         if (i != 5) tick();
      end
   endtask

   task automatic test_upper();
      logic [6:0]  ops [2];
      logic [16:0] exp [5];
      ops = '{7'b0110111, 7'b0010111};
      for (int c = 0; c < 2; c++) begin
         op  = ops[c];
         exp = '{FETCH_RDY, DEC, (c == 0 ? LUI : AUIPC), ALUWB, FETCH_RDY};
         for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (sig !== exp[i]) begin
               n_fail++;
               $display("FAIL upper op %0d step %0d: sig %05h want %05h", c, i, sig, exp[i]);
            end
            if (i != 4) tick();
         end
      end
   endtask

   task automatic test_illegal();
      logic [16:0] exp_ill [4];
      logic [16:0] exp_sys [4];
`ifdef ZICSR_TRAP_EN
      exp_ill = '{FETCH_RDY, DEC_ILL, TRAP, FETCH_RDY};
      exp_sys = '{FETCH_RDY, DEC, TRAP, FETCH_RDY};
`else
      exp_ill = '{FETCH_RDY, DEC_ILL, FETCH_RDY, DEC_ILL};
      exp_sys = '{FETCH_RDY, DEC_ILL, FETCH_RDY, DEC_ILL};
`endif
      op = 7'b0000000;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (sig !== exp_ill[i]) begin
            n_fail++;
            $display("FAIL illegal step %0d: sig %05h want %05h", i, sig, exp_ill[i]);
         end
         if (i != 3) tick();
      end
`ifndef ZICSR_TRAP_EN
      tick();
`endif
      op = 7'b1110011;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (sig !== exp_sys[i]) begin
            n_fail++;
            $display("FAIL system step %0d: sig %05h want %05h", i, sig, exp_sys[i]);
         end
         if (i != 3) tick();
      end
`ifndef ZICSR_TRAP_EN
      tick();
`endif
   endtask

   task automatic test_reset_mid();
      op = 7'b0010011;
      mem_ready = 1'b1;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (sig !== 17'b0) begin
         n_fail++;
         $display("FAIL reset_mid_aluwb: sig %05h want 00000", sig);
      end
      tick();
      n_cmp++;
      if (sig !== FETCH_STL) begin
         n_fail++;
         $display("FAIL reset_mid_fetch: sig %05h want %05h", sig, FETCH_STL);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (sig !== FETCH_RDY) begin
         n_fail++;
         $display("FAIL reset_mid_release: sig %05h want %05h", sig, FETCH_RDY);
      end
   endtask

   task automatic test_watchdog();
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (bus_err !== 1'b0 || sig !== FETCH_STL) begin
            n_fail++;
            $display("FAIL wd_pre cycle %0d: bus_err %b sig %05h want 0 %05h", i, bus_err, sig, FETCH_STL);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (bus_err !== 1'b1 || sig !== FETCH_STL) begin
            n_fail++;
            $display("FAIL wd_post cycle %0d: bus_err %b sig %05h want 1 %05h", i, bus_err, sig, FETCH_STL);
         end
         tick();
      end
      mem_ready = 1'b1;
      test_addi();
      n_cmp++;
      if (bus_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_sticky: got %b want 1", bus_err);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_rtype();
      test_load_stall();
      test_store_ready_wins();
      test_branch();
      test_jumps();
      test_upper();
      test_illegal();
      test_reset_mid();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
